// File: rtl/bp_mem_block_responder.sv
// Memory-end responder for the CCE memory interface: one command at a time, fixed-latency
// responses from a block array. Message layout (LSB first): msg_type[4], addr, size[3], payload, data.
module bp_mem_block_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int payload_width_p   = 16,
    parameter int mem_els_p         = 512,
    parameter int latency_p         = 4,
    localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + payload_width_p + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_yumi_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_ready_i
);

    localparam int BYTES_LP = cce_block_width_p / 8;
    localparam int OFF_W_LP = $clog2(BYTES_LP);
    localparam int IDX_W_LP = $clog2(mem_els_p);
    localparam int CNT_W_LP = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

    localparam int ADDR_LSB_LP = 4;
    localparam int SIZE_LSB_LP = ADDR_LSB_LP + paddr_width_p;
    localparam int PAY_LSB_LP  = SIZE_LSB_LP + 3;
    localparam int DATA_LSB_LP = PAY_LSB_LP + payload_width_p;

    localparam logic [3:0] CMD_RD    = 4'h0;
    localparam logic [3:0] CMD_WB    = 4'h1;
    localparam logic [3:0] CMD_UC_RD = 4'h2;
    localparam logic [3:0] CMD_UC_WR = 4'h3;
    localparam logic [3:0] RESP_BIT  = 4'h8;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W_LP-1:0]            cnt_q, cnt_d;
    logic [IDX_W_LP-1:0]            clr_idx_q, clr_idx_d;
    logic [cce_mem_msg_width_lp-1:0] resp_q, resp_d;
    logic                           resp_v_q;

    logic [3:0]                     type_q;
    logic [paddr_width_p-1:0]       addr_q;
    logic [2:0]                     size_q;
    logic [payload_width_p-1:0]     payload_q;

    logic [cce_block_width_p-1:0]   mem_q [mem_els_p];

    logic [3:0]                     cmd_type;
    logic [paddr_width_p-1:0]       cmd_addr;
    logic [2:0]                     cmd_size;
    logic [payload_width_p-1:0]     cmd_payload;
    logic [cce_block_width_p-1:0]   cmd_data;

    assign cmd_type    = mem_cmd_i[3:0];
    assign cmd_addr    = mem_cmd_i[ADDR_LSB_LP +: paddr_width_p];
    assign cmd_size    = mem_cmd_i[SIZE_LSB_LP +: 3];
    assign cmd_payload = mem_cmd_i[PAY_LSB_LP +: payload_width_p];
    assign cmd_data    = mem_cmd_i[DATA_LSB_LP +: cce_block_width_p];

    assign mem_cmd_yumi_o = (state_q == IDLE) && mem_cmd_v_i;
    assign mem_resp_o     = resp_q;
    assign mem_resp_v_o   = resp_v_q;

    // With zero latency the response is built in the accept cycle, before the header latch is valid.
    logic                           use_cmd;
    logic [3:0]                     src_type;
    logic [paddr_width_p-1:0]       src_addr;
    logic [2:0]                     src_size;
    logic [payload_width_p-1:0]     src_payload;
    logic [IDX_W_LP-1:0]            src_idx;
    logic [OFF_W_LP-1:0]            src_off;

    assign use_cmd     = (state_q == IDLE);
    assign src_type    = use_cmd ? cmd_type    : type_q;
    assign src_addr    = use_cmd ? cmd_addr    : addr_q;
    assign src_size    = use_cmd ? cmd_size    : size_q;
    assign src_payload = use_cmd ? cmd_payload : payload_q;
    assign src_idx     = src_addr[OFF_W_LP +: IDX_W_LP];
    assign src_off     = src_addr[OFF_W_LP-1:0];

    logic [cce_block_width_p-1:0]   rd_blk, rd_sh, wd_sh, resp_data;
    logic [cce_block_width_p-1:0]   size_bits, wr_bits;
    logic [BYTES_LP-1:0]            size_bmask, wr_bmask;

    assign rd_blk = mem_q[src_idx];
    assign rd_sh  = rd_blk >> {src_off, 3'b000};
    assign wd_sh  = cmd_data << {src_off, 3'b000};

    always_comb begin
        size_bmask = '0;
        for (int b = 0; b < BYTES_LP; b++) begin
            size_bmask[b] = ((b >> src_size) == 0);
        end
        wr_bmask = size_bmask << src_off;
        size_bits = '0;
        wr_bits   = '0;
        for (int b = 0; b < BYTES_LP; b++) begin
            size_bits[b*8 +: 8] = {8{size_bmask[b]}};
            wr_bits[b*8 +: 8]   = {8{wr_bmask[b]}};
        end
    end

    always_comb begin
        resp_data = '0;
        case (src_type)
            CMD_RD:    resp_data = rd_blk;
            CMD_UC_RD: resp_data = rd_sh & size_bits;
            default:   resp_data = '0;
        endcase
        resp_d = {resp_data, src_payload, src_size, src_addr, src_type | RESP_BIT};
    end

    logic                           mem_we;
    logic [IDX_W_LP-1:0]            mem_wa;
    logic [cce_block_width_p-1:0]   mem_wd;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = src_idx;
        mem_wd = '0;
        if (state_q == CLEAR) begin
            mem_we = reset_n_i;
            mem_wa = clr_idx_q;
        end else if (mem_cmd_yumi_o && reset_n_i) begin
            if (cmd_type == CMD_WB) begin
                mem_we = 1'b1;
                mem_wd = cmd_data;
            end else if (cmd_type == CMD_UC_WR) begin
                mem_we = 1'b1;
                mem_wd = (rd_blk & ~wr_bits) | (wd_sh & wr_bits);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W_LP'(mem_els_p - 1)) begin
                    clr_idx_d = '0;
                    state_d   = IDLE;
                end
            end
            IDLE: begin
                if (mem_cmd_yumi_o) begin
                    if (latency_p == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W_LP'(latency_p);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W_LP'(1)) state_d = RESP;
            end
            RESP: begin
                if (mem_resp_ready_i) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            resp_q    <= '0;
            resp_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            resp_v_q  <= (state_d == RESP);
            // Read data is captured once, on entry to RESP, and held through backpressure.
            if ((state_d == RESP) && (state_q != RESP)) resp_q <= resp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_cmd_yumi_o) begin
            type_q    <= cmd_type;
            addr_q    <= cmd_addr;
            size_q    <= cmd_size;
            payload_q <= cmd_payload;
        end
    end

endmodule

// File: tb/tb_bp_mem_block_responder.sv
// Scoreboard bench: two responders (latency 2 and latency 0), 8 blocks of 64B each.
module tb_bp_mem_block_responder;

    localparam int PA    = 40;
    localparam int BW    = 512;
    localparam int PL    = 16;
    localparam int ELS   = 8;
    localparam int MSG_W = 4 + PA + 3 + PL + BW;

    localparam logic [3:0] RD = 4'h0, WB = 4'h1, UCRD = 4'h2, UCWR = 4'h3, BAD = 4'h5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [MSG_W-1:0] cmd    [2];
    logic             cmd_v  [2];
    logic             yumi   [2];
    logic [MSG_W-1:0] resp   [2];
    logic             resp_v [2];
    logic             ready  [2];

    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;
    logic [MSG_W-1:0] expq0[$];
    logic [MSG_W-1:0] expq1[$];

    bp_mem_block_responder #(
        .paddr_width_p(PA), .cce_block_width_p(BW), .payload_width_p(PL),
        .mem_els_p(ELS), .latency_p(2)
    ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_i(cmd[0]), .mem_cmd_v_i(cmd_v[0]), .mem_cmd_yumi_o(yumi[0]),
        .mem_resp_o(resp[0]), .mem_resp_v_o(resp_v[0]), .mem_resp_ready_i(ready[0])
    );

    bp_mem_block_responder #(
        .paddr_width_p(PA), .cce_block_width_p(BW), .payload_width_p(PL),
        .mem_els_p(ELS), .latency_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_i(cmd[1]), .mem_cmd_v_i(cmd_v[1]), .mem_cmd_yumi_o(yumi[1]),
        .mem_resp_o(resp[1]), .mem_resp_v_o(resp_v[1]), .mem_resp_ready_i(ready[1])
    );

    // Cycle 0 is the first cycle with reset deasserted.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    function automatic logic [MSG_W-1:0] mk(input logic [3:0] t, input logic [PA-1:0] a,
                                            input logic [2:0] s, input logic [PL-1:0] p,
                                            input logic [BW-1:0] d);
        return {d, p, s, a, t};
    endfunction

    task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_v[0] && ready[0]) begin
            if (expq0.size() == 0) begin
                n_tot++;
                $display("FAIL resp0_unexpected: got %0h want none", resp[0]);
            end else check("resp0", resp[0], expq0.pop_front());
        end
        if (rst_n && resp_v[1] && ready[1]) begin
            if (expq1.size() == 0) begin
                n_tot++;
                $display("FAIL resp1_unexpected: got %0h want none", resp[1]);
            end else check("resp1", resp[1], expq1.pop_front());
        end
    end

    task automatic issue(input int sel, input logic [MSG_W-1:0] c, input logic [MSG_W-1:0] e,
                         input bit push, output int yc);
        int n;
        n = 0;
        cmd[sel]   = c;
        cmd_v[sel] = 1'b1;
        @(negedge clk);
        while (!yumi[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        yc = cyc;
        if (!yumi[sel]) begin
            n_tot++;
            $display("FAIL yumi_timeout%0d: got no yumi want yumi", sel);
        end else if (push) begin
            if (sel == 0) expq0.push_back(e);
            else expq1.push_back(e);
        end
        @(posedge clk);
        #1 cmd_v[sel] = 1'b0;
    endtask

    task automatic wait_resp(input int sel, input int yc, input int lat, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_v[sel] && n < 50);
        check(name, cyc, yc + 1 + lat);
    endtask

    task automatic txn(input int sel, input logic [MSG_W-1:0] c, input logic [MSG_W-1:0] e,
                       input string name);
        int yc;
        issue(sel, c, e, 1'b1, yc);
        wait_resp(sel, yc, (sel == 0) ? 2 : 0, name);
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] blk1, blk2, pat, ones, uc4, uc8;
    logic [MSG_W-1:0] e1;
    int yc, rc;

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cmd[s] = '0; cmd_v[s] = 1'b0; ready[s] = 1'b1;
        end
        blk1 = {64{8'hA5}};
        blk2 = blk1;
        blk2[127:64] = 64'h1122334455667788;
        pat  = {16{32'hDEADBEEF}};
        ones = '1;
        uc4  = 512'h11223344;
        uc8  = 512'hA5A5A5A5A5A5A5A5;

        // Reset with a command pending: nothing accepted, outputs at reset values.
        cmd[0] = mk(RD, 40'h0, 3'd6, 16'd1, '0);
        cmd_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_yumi", yumi[0], 0);
        check("rst_resp_v", resp_v[0], 0);
        check("rst_resp", resp[0], 0);
        check("rst_resp_v_lat0", resp_v[1], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < ELS; i++) begin
            @(negedge clk);
            check($sformatf("clear_c%0d", i), {yumi[0], resp_v[0]}, 0);
        end
        issue(0, mk(RD, 40'h0, 3'd6, 16'd1, '0), mk(RD | 4'h8, 40'h0, 3'd6, 16'd1, '0), 1'b1, yc);
        check("first_yumi_cycle", yc, 8);
        wait_resp(0, yc, 2, "first_resp_cycle");
        @(posedge clk);
        #1;

        txn(0, mk(WB, 40'h40, 3'd6, 16'd2, blk1), mk(WB | 4'h8, 40'h40, 3'd6, 16'd2, '0), "wb_lat");
        txn(0, mk(RD, 40'h40, 3'd6, 16'd3, '0), mk(RD | 4'h8, 40'h40, 3'd6, 16'd3, blk1), "rd_lat");
        txn(0, mk(UCWR, 40'h48, 3'd3, 16'd4, 512'h1122334455667788),
               mk(UCWR | 4'h8, 40'h48, 3'd3, 16'd4, '0), "ucwr_lat");
        txn(0, mk(UCRD, 40'h4C, 3'd2, 16'd5, '0), mk(UCRD | 4'h8, 40'h4C, 3'd2, 16'd5, uc4), "ucrd4_lat");
        txn(0, mk(UCRD, 40'h78, 3'd3, 16'd6, '0), mk(UCRD | 4'h8, 40'h78, 3'd3, 16'd6, uc8), "ucrd8_lat");
        txn(0, mk(RD, 40'h40, 3'd6, 16'd7, '0), mk(RD | 4'h8, 40'h40, 3'd6, 16'd7, blk2), "rd_merge_lat");
        txn(0, mk(BAD, 40'h40, 3'd6, 16'd8, ones), mk(BAD | 4'h8, 40'h40, 3'd6, 16'd8, '0), "bad_lat");
        txn(0, mk(RD, 40'h40, 3'd6, 16'd9, '0), mk(RD | 4'h8, 40'h40, 3'd6, 16'd9, blk2), "rd_after_bad_lat");

        // Zero latency and address aliasing on the second responder.
        txn(1, mk(WB, 40'h0, 3'd6, 16'd10, pat), mk(WB | 4'h8, 40'h0, 3'd6, 16'd10, '0), "l0_wb_lat");
        txn(1, mk(RD, 40'h200, 3'd6, 16'd11, '0), mk(RD | 4'h8, 40'h200, 3'd6, 16'd11, pat), "l0_alias_lat");
        txn(1, mk(RD, 40'h240, 3'd6, 16'd12, '0), mk(RD | 4'h8, 40'h240, 3'd6, 16'd12, '0), "l0_alias1_lat");

        // Backpressure: response held, second command waits until after the transfer.
        ready[0] = 1'b0;
        e1 = mk(RD | 4'h8, 40'h40, 3'd6, 16'd20, blk2);
        issue(0, mk(RD, 40'h40, 3'd6, 16'd20, '0), e1, 1'b1, yc);
        wait_resp(0, yc, 2, "bp_resp_cycle");
        cmd[0] = mk(RD, 40'h0, 3'd6, 16'd21, '0);
        cmd_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_resp", resp[0], e1);
            check("bp_hold_ctl", {resp_v[0], yumi[0]}, 2'b10);
        end
        @(posedge clk);
        #1 ready[0] = 1'b1;
        rc = cyc;
        issue(0, mk(RD, 40'h0, 3'd6, 16'd21, '0), mk(RD | 4'h8, 40'h0, 3'd6, 16'd21, '0), 1'b1, yc);
        check("bp_next_yumi", yc, rc + 1);
        wait_resp(0, yc, 2, "bp_next_resp");
        @(posedge clk);
        #1;

        // Reset during WAIT: response dropped, full CLEAR re-runs.
        issue(0, mk(RD, 40'h40, 3'd6, 16'd30, '0), '0, 1'b0, yc);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmd[0] = mk(RD, 40'h40, 3'd6, 16'd31, '0);
        cmd_v[0] = 1'b1;
        for (int i = 0; i < ELS; i++) begin
            @(negedge clk);
            check($sformatf("reclear_c%0d", i), {yumi[0], resp_v[0]}, 0);
        end
        issue(0, mk(RD, 40'h40, 3'd6, 16'd31, '0), mk(RD | 4'h8, 40'h40, 3'd6, 16'd31, '0), 1'b1, yc);
        check("reclear_yumi_cycle", yc, 8);
        wait_resp(0, yc, 2, "reclear_resp_cycle");
        @(posedge clk);
        #1;

        repeat (3) @(negedge clk);
        check("drain0", expq0.size(), 0);
        check("drain1", expq1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
